// File: rtl/bch_job_ctrl.sv
// bch_job_ctrl: AXI4-Lite register front-end that launches and supervises
// one BCH encode/decode job at a time on the codec core, with a completion
// timeout. Optional feature macro: BCH_JOB_CTRL_IRQ_EN (CTRL.IRQ_EN + irq).
module bch_job_ctrl #(
    parameter int CW_W        = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_axil_awvalid,
    output logic            s_axil_awready,
    input  logic [20:0]     s_axil_awaddr,
    input  logic [2:0]      s_axil_awprot,
    input  logic            s_axil_wvalid,
    output logic            s_axil_wready,
    input  logic [31:0]     s_axil_wdata,
    input  logic [3:0]      s_axil_wstrb,
    output logic            s_axil_bvalid,
    input  logic            s_axil_bready,
    output logic [1:0]      s_axil_bresp,
    input  logic            s_axil_arvalid,
    output logic            s_axil_arready,
    input  logic [20:0]     s_axil_araddr,
    input  logic [2:0]      s_axil_arprot,
    output logic            s_axil_rvalid,
    input  logic            s_axil_rready,
    output logic [31:0]     s_axil_rdata,
    output logic [1:0]      s_axil_rresp,
    output logic            cdc_start,
    output logic            cdc_mode,
    output logic [CW_W-1:0] cdc_din,
    input  logic            cdc_done,
    input  logic [CW_W-1:0] cdc_dout,
    input  logic [3:0]      cdc_nerr,
    output logic            irq
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_DIN    = 2'd2;
    localparam logic [1:0] R_DOUT   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]       state;
    logic [CNT_W-1:0] tcnt;
    logic             bus_en;
    logic             mode_q;
    logic             done_q;
    logic             tout_q;
    logic [3:0]       nerr_q;
    logic [CW_W-1:0]  din_q;
    logic [CW_W-1:0]  dout_q;
    logic [31:0]      din_wr;
    logic [31:0]      rd_val;
    logic             busy;
    logic             wr_hs;
    logic             rd_hs;
    logic             wr_ok;
    logic             rd_ok;
    logic [1:0]       wr_reg;
    logic [1:0]       rd_reg;
    logic             wr_err;
    logic             wr_acc;
    logic             start_go;
    logic             job_done;
    logic             job_tout;
    logic             clr_done;
    logic             clr_tout;
    logic             unused_bits;

`ifdef BCH_JOB_CTRL_IRQ_EN
    logic             irq_en_q;
`endif

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Handshakes are held off until the first clock after reset release so
    // every ready output is low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_en <= 1'b0;
        else        bus_en <= 1'b1;
    end

    assign wr_hs          = bus_en & s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid;
    assign s_axil_awready = wr_hs;
    assign s_axil_wready  = wr_hs;
    assign rd_hs          = bus_en & s_axil_arvalid & ~s_axil_rvalid;
    assign s_axil_arready = bus_en & ~s_axil_rvalid;

    assign busy     = (state != ST_IDLE);
    assign wr_ok    = (s_axil_awaddr[20:4] == '0);
    assign wr_reg   = s_axil_awaddr[3:2];
    assign rd_ok    = (s_axil_araddr[20:4] == '0);
    assign rd_reg   = s_axil_araddr[3:2];
    assign wr_err   = ~wr_ok | (busy & ((wr_reg == R_CTRL) | (wr_reg == R_DIN)));
    assign wr_acc   = wr_hs & ~wr_err;
    assign start_go = wr_acc & (wr_reg == R_CTRL) & s_axil_wstrb[0] & s_axil_wdata[0];
    assign job_done = (state == ST_WAIT) & cdc_done;
    assign job_tout = (state == ST_WAIT) & ~cdc_done & (tcnt == CNT_W'(TIMEOUT_CYC - 1));
    assign clr_done = wr_acc & (wr_reg == R_STATUS) & s_axil_wstrb[0] & s_axil_wdata[1];
    assign clr_tout = wr_acc & (wr_reg == R_STATUS) & s_axil_wstrb[0] & s_axil_wdata[2];

    // Job sequencer: IDLE -> ISSUE (start pulse) -> WAIT (done or timeout).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_go) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cdc_done || job_tout) state <= ST_IDLE;
                    else                      tcnt  <= tcnt + CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte-strobe merge of the incoming DIN write.
    always_comb begin
        din_wr = 32'(din_q);
        for (int unsigned i = 0; i < 4; i++) begin
            if (s_axil_wstrb[i]) din_wr[8*i +: 8] = s_axil_wdata[8*i +: 8];
        end
    end

    // Software configuration: MODE, IRQ_EN and DIN (only accepted while idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
`ifdef BCH_JOB_CTRL_IRQ_EN
            irq_en_q <= 1'b0;
`endif
            din_q    <= '0;
        end else begin
            if (wr_acc && (wr_reg == R_CTRL) && s_axil_wstrb[0]) begin
                mode_q   <= s_axil_wdata[1];
`ifdef BCH_JOB_CTRL_IRQ_EN
                irq_en_q <= s_axil_wdata[2];
`endif
            end
            if (wr_acc && (wr_reg == R_DIN)) din_q <= din_wr[CW_W-1:0];
        end
    end

    // Job results and sticky flags; a flag being set beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            tout_q <= 1'b0;
            nerr_q <= '0;
            dout_q <= '0;
        end else begin
            if (job_done) begin
                done_q <= 1'b1;
                nerr_q <= cdc_nerr;
                dout_q <= cdc_dout;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end
            if (job_tout)      tout_q <= 1'b1;
            else if (clr_tout) tout_q <= 1'b0;
        end
    end

    // Read data mux over pre-edge register values.
    always_comb begin
        rd_val = '0;
        case (rd_reg)
            R_CTRL: begin
                rd_val[1] = mode_q;
`ifdef BCH_JOB_CTRL_IRQ_EN
                rd_val[2] = irq_en_q;
`endif
            end
            R_STATUS: begin
                rd_val[0]    = busy;
                rd_val[1]    = done_q;
                rd_val[2]    = tout_q;
                rd_val[11:8] = nerr_q;
            end
            R_DIN:   rd_val = 32'(din_q);
            R_DOUT:  rd_val = 32'(dout_q);
            default: rd_val = '0;
        endcase
        if (!rd_ok) rd_val = '0;
    end

    // Write response channel: one outstanding write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else if (wr_hs) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
        end
    end

    // Read data channel: one outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (rd_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_val;
            s_axil_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    assign cdc_start = (state == ST_ISSUE);
    assign cdc_mode  = mode_q;
    assign cdc_din   = din_q;

`ifdef BCH_JOB_CTRL_IRQ_EN
    assign irq = irq_en_q & (done_q | tout_q);
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bch_job_ctrl.sv
// Directed self-checking bench for bch_job_ctrl (TIMEOUT_CYC = 15).
module tb_bch_job_ctrl;

    localparam int TO = 15;
`ifdef BCH_JOB_CTRL_IRQ_EN
    localparam logic HAS_IRQ = 1'b1;
`else
    localparam logic HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
    logic [20:0] awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [1:0]  bresp, rresp;
    logic        cdc_start, cdc_mode, cdc_done = 1'b0, irq;
    logic [31:0] cdc_din, cdc_dout = '0;
    logic [3:0]  cdc_nerr = '0;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    int unsigned start_edge = 0;
    logic        start_mode = 1'b0;
    logic [31:0] start_din = '0;
    logic [1:0]  resp;
    logic [31:0] data;

    bch_job_ctrl #(.CW_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_awprot(awprot), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_bvalid(bvalid),
        .s_axil_bready(bready), .s_axil_bresp(bresp), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready), .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata),
        .s_axil_rresp(rresp), .cdc_start(cdc_start), .cdc_mode(cdc_mode),
        .cdc_din(cdc_din), .cdc_done(cdc_done), .cdc_dout(cdc_dout),
        .cdc_nerr(cdc_nerr), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records each start pulse; start_edge is the edge that enters WAIT.
    always @(negedge clk) begin
        if (cdc_start) begin
            start_cnt  = start_cnt + 1;
            start_edge = cyc + 1;
            start_mode = cdc_mode;
            start_din  = cdc_din;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running exp finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned t);
        int g = 0;
        while (cyc < t && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
    endtask

    task automatic axi_write(input logic [20:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        int g = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!awready && g < 20) begin @(posedge clk); #1; g++; end
        if (g == 20) begin
            n_vec++; n_err++;
            $display("FAIL aw_timeout: got awready=0 exp 1");
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        g = 0;
        while (!bvalid && g < 20) begin @(posedge clk); #1; g++; end
        r = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [20:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        int g = 0;
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && g < 20) begin @(posedge clk); #1; g++; end
        if (g == 20) begin
            n_vec++; n_err++;
            $display("FAIL ar_timeout: got arready=0 exp 1");
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        g = 0;
        while (!rvalid && g < 20) begin @(posedge clk); #1; g++; end
        d = rdata; r = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] d, input logic [3:0] n);
        cdc_dout = d; cdc_nerr = n; cdc_done = 1'b1;
        tick(1);
        cdc_done = 1'b0;
    endtask

    task automatic test_reset;
        logic [76:0] outs;
        #1 rst_n = 1'b0;
        #2;
        outs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
                cdc_start, cdc_mode, cdc_din, irq};
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h exp 0", outs); end
        tick(3);
        rst_n = 1'b1;
        tick(2);
        axi_read(21'h04, data, resp);
        n_vec++;
        if ({resp, data} !== 34'h0) begin n_err++; $display("FAIL reset_status: got %h exp 0", {resp, data}); end
        axi_read(21'h00, data, resp);
        n_vec++;
        if (data !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h exp 0", data); end
    endtask

    task automatic test_encode;
        int unsigned s0;
        axi_write(21'h08, 32'h0000_00A5, 4'hF, resp);
        n_vec++;
        if (resp !== 2'b00) begin n_err++; $display("FAIL enc_din_bresp: got %b exp 00", resp); end
        s0 = start_cnt;
        axi_write(21'h00, 32'h1, 4'hF, resp);
        n_vec++;
        if ({start_cnt - s0, start_mode, start_din} !== {32'd1, 1'b0, 32'hA5}) begin
            n_err++;
            $display("FAIL enc_start: got cnt=%0d mode=%b din=%h exp cnt=1 mode=0 din=a5", start_cnt - s0, start_mode, start_din);
        end
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'h1) begin n_err++; $display("FAIL enc_busy: got %h exp 1", data); end
        wait_cyc(start_edge + 10);
        pulse_done(32'h1234_5678, 4'h0);
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'h2) begin n_err++; $display("FAIL enc_status: got %h exp 2", data); end
        axi_read(21'h0C, data, resp);
        n_vec++;
        if (data !== 32'h1234_5678) begin n_err++; $display("FAIL enc_dout: got %h exp 12345678", data); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL enc_irq: got %b exp 0", irq); end
    endtask

    task automatic test_decode_irq;
        axi_write(21'h04, 32'h2, 4'hF, resp);
        axi_write(21'h00, 32'h7, 4'hF, resp);
        n_vec++;
        if (start_mode !== 1'b1) begin n_err++; $display("FAIL dec_mode: got %b exp 1", start_mode); end
        axi_read(21'h00, data, resp);
        n_vec++;
        if (data !== (HAS_IRQ ? 32'h6 : 32'h2)) begin
            n_err++; $display("FAIL dec_ctrl: got %h exp %h", data, HAS_IRQ ? 32'h6 : 32'h2);
        end
        wait_cyc(start_edge + 5);
        pulse_done(32'hCAFE_F00D, 4'h3);
        n_vec++;
        if (irq !== HAS_IRQ) begin n_err++; $display("FAIL dec_irq_set: got %b exp %b", irq, HAS_IRQ); end
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'h302) begin n_err++; $display("FAIL dec_status: got %h exp 302", data); end
        axi_write(21'h04, 32'h2, 4'hF, resp);
        axi_read(21'h04, data, resp);
        n_vec++;
        if ({data, irq} !== {32'h300, 1'b0}) begin
            n_err++; $display("FAIL dec_w1c: got status=%h irq=%b exp status=300 irq=0", data, irq);
        end
    endtask

    task automatic test_timeout;
        axi_write(21'h00, 32'h1, 4'hF, resp);
        wait_cyc(start_edge + TO - 1);
        araddr = 21'h04; arvalid = 1'b1;
        #1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        n_vec++;
        if ({rvalid, rdata} !== {1'b1, 32'h301}) begin
            n_err++; $display("FAIL tout_last_busy: got v=%b d=%h exp v=1 d=301", rvalid, rdata);
        end
        cdc_dout = 32'hDEAD_BEEF; cdc_nerr = 4'h9; cdc_done = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        cdc_done = 1'b0; rready = 1'b0;
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'h304) begin n_err++; $display("FAIL tout_status: got %h exp 304", data); end
        axi_read(21'h0C, data, resp);
        n_vec++;
        if (data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL tout_dout: got %h exp cafef00d", data); end
    endtask

    task automatic test_done_wins;
        axi_write(21'h04, 32'h4, 4'hF, resp);
        axi_write(21'h00, 32'h1, 4'hF, resp);
        wait_cyc(start_edge + TO - 1);
        pulse_done(32'h0BAD_C0DE, 4'hF);
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'hF02) begin n_err++; $display("FAIL done_wins_status: got %h exp f02", data); end
        axi_read(21'h0C, data, resp);
        n_vec++;
        if (data !== 32'h0BAD_C0DE) begin n_err++; $display("FAIL done_wins_dout: got %h exp 0badc0de", data); end
    endtask

    task automatic test_busy_guard;
        int unsigned s0;
        axi_write(21'h04, 32'h2, 4'hF, resp);
        axi_write(21'h08, 32'h0000_3C3C, 4'hF, resp);
        s0 = start_cnt;
        axi_write(21'h00, 32'h1, 4'hF, resp);
        axi_write(21'h08, 32'h0000_0055, 4'hF, resp);
        n_vec++;
        if (resp !== 2'b10) begin n_err++; $display("FAIL busy_din_bresp: got %b exp 10", resp); end
        axi_write(21'h00, 32'h1, 4'hF, resp);
        n_vec++;
        if (resp !== 2'b10) begin n_err++; $display("FAIL busy_ctrl_bresp: got %b exp 10", resp); end
        axi_write(21'h04, 32'h0, 4'hF, resp);
        n_vec++;
        if (resp !== 2'b00) begin n_err++; $display("FAIL busy_status_bresp: got %b exp 00", resp); end
        axi_read(21'h08, data, resp);
        n_vec++;
        if ({data, cdc_din} !== {32'h3C3C, 32'h3C3C}) begin
            n_err++; $display("FAIL busy_din_kept: got reg=%h pin=%h exp 3c3c", data, cdc_din);
        end
        wait_cyc(start_edge + TO + 2);
        n_vec++;
        if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL busy_starts: got %0d exp 1", start_cnt - s0); end
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'hF04) begin n_err++; $display("FAIL busy_tout_status: got %h exp f04", data); end
        axi_write(21'h04, 32'h4, 4'hF, resp);
    endtask

    task automatic test_bus_edges;
        logic ok;
        axi_read(21'h14, data, resp);
        n_vec++;
        if ({resp, data} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL bad_rd_0x14: got %b/%h exp 10/0", resp, data); end
        axi_read(21'h10_0004, data, resp);
        n_vec++;
        if ({resp, data} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL bad_rd_high: got %b/%h exp 10/0", resp, data); end
        axi_write(21'h1C, 32'hFFFF_FFFF, 4'hF, resp);
        n_vec++;
        if (resp !== 2'b10) begin n_err++; $display("FAIL bad_wr_0x1c: got %b exp 10", resp); end
        axi_write(21'h08, 32'hFFFF_FFFF, 4'h2, resp);
        axi_read(21'h08, data, resp);
        n_vec++;
        if (data !== 32'h0000_FF3C) begin n_err++; $display("FAIL din_strobe: got %h exp 0000ff3c", data); end
        // bready held low for 5 cycles while a further write is offered
        awaddr = 21'h08; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        @(posedge clk); #1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0)) ok = 1'b0;
            tick(1);
        end
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL bready_hold: got ok=%b exp 1", ok); end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick(1);
        bready = 1'b0;
        // rready held low for 5 cycles while a further read is offered
        araddr = 21'h0C; arvalid = 1'b1;
        #1;
        @(posedge clk); #1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(rvalid === 1'b1 && arready === 1'b0 && rdata === 32'h0BAD_C0DE)) ok = 1'b0;
            tick(1);
        end
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL rready_hold: got ok=%b exp 1", ok); end
        arvalid = 1'b0; rready = 1'b1;
        tick(1);
        rready = 1'b0;
    endtask

    task automatic test_back_to_back;
        awaddr = 21'h08; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 21'h08; arvalid = 1'b1;
        #1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_vec++;
        if ({bvalid, rvalid, rdata} !== {2'b11, 32'h1234_5678}) begin
            n_err++; $display("FAIL same_cycle_rw: got b=%b r=%b d=%h exp 1 1 12345678", bvalid, rvalid, rdata);
        end
        bready = 1'b1; rready = 1'b1;
        tick(1);
        bready = 1'b0; rready = 1'b0;
        axi_read(21'h08, data, resp);
        n_vec++;
        if (data !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL same_cycle_din: got %h exp a5a5a5a5", data); end
    endtask

    task automatic test_reset_mid_job;
        logic [35:0] pins;
        axi_write(21'h00, 32'h3, 4'hF, resp);
        tick(3);
        n_vec++;
        if ({cdc_mode, cdc_din} !== {1'b1, 32'hA5A5_A5A5}) begin
            n_err++; $display("FAIL mid_job_pins: got %b/%h exp 1/a5a5a5a5", cdc_mode, cdc_din);
        end
        #2 rst_n = 1'b0;
        #1;
        pins = {cdc_start, cdc_mode, arready, irq, cdc_din};
        n_vec++;
        if (pins !== '0) begin n_err++; $display("FAIL async_reset_pins: got %h exp 0", pins); end
        tick(2);
        rst_n = 1'b1;
        tick(3);
        pulse_done(32'h7777_7777, 4'h7);
        axi_read(21'h04, data, resp);
        n_vec++;
        if (data !== 32'h0) begin n_err++; $display("FAIL late_done_status: got %h exp 0", data); end
        axi_read(21'h0C, data, resp);
        n_vec++;
        if (data !== 32'h0) begin n_err++; $display("FAIL late_done_dout: got %h exp 0", data); end
    endtask

    initial begin
        test_reset;
        test_encode;
        test_decode_irq;
        test_timeout;
        test_done_wins;
        test_busy_guard;
        test_bus_edges;
        test_back_to_back;
        test_reset_mid_job;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
